seg7_scan_mux: RTL

//  Parametrised time-multiplexed driver for an N-digit common-anode seven-segment display.

---
 rtl/seg7_scan_mux_if.sv | 39 +++
 rtl/seg7_scan_mux.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux_if.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux_if
//   Bundles the datapath-facing and pin-facing signals of seg7_scan_mux.
//   master : datapath side (drives digit data/strobes, observes pins)
//   slave  : seg7_scan_mux side
// Signals
//   digits_in  [4*NUM_DIGITS]  nibble i = code for digit i
//   dp_in      [NUM_DIGITS]    decimal point request per digit (1 = on)
//   blank_in   [NUM_DIGITS]    per-digit force-blank (1 = blank digit and dp)
//   load                       1-cycle capture strobe into the pending buffer
//   lz_en                      leading-zero suppression enable (live)
//   anode      [NUM_DIGITS]    active-low digit enables
//   segment    [7]             active-low segments, [6:0] = a..g
//   dp                         active-low decimal point
//   frame_done                 1-cycle pulse in the last cycle of digit N-1
// -----------------------------------------------------------------------------
interface seg7_scan_mux_if #(
   parameter int NUM_DIGITS = 4
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic [NUM_DIGITS-1:0]   blank_in;
   logic                    load;
   logic                    lz_en;
   logic [NUM_DIGITS-1:0]   anode;
   logic [6:0]              segment;
   logic                    dp;
   logic                    frame_done;

   modport master (
      output digits_in, dp_in, blank_in, load, lz_en,
      input  anode, segment, dp, frame_done
   );

   modport slave (
      input  digits_in, dp_in, blank_in, load, lz_en,
      output anode, segment, dp, frame_done
   );
endinterface

// File: rtl/seg7_scan_mux.sv
// -----------------------------------------------------------------------------
// seg7_scan_mux
//   Time-multiplexed driver for an N-digit common-anode seven-segment display.
//   Digits are scanned round-robin, one slot of REFRESH_DIV clocks each; the
//   first BLANK_CYC clocks of every slot keep all anodes off (anti-ghosting).
//   Digit data is double-buffered: loads land in a pending buffer that is
//   committed to the display registers only at the end of a frame, so a frame
//   never mixes old and new values. Hex/decimal decode, decimal points,
//   per-digit blanking and leading-zero suppression are applied on the way out.
// Ports
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : seg7_scan_mux_if.slave (digit data, strobes, display pins)
// -----------------------------------------------------------------------------
module seg7_scan_mux #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int BLANK_CYC   = 1000,
   parameter int HEX_EN      = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   seg7_scan_mux_if.slave bus
);

   localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int DW    = 4 * NUM_DIGITS;

   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] DIG_LAST  = IDX_W'(NUM_DIGITS - 1);

   // ---------------------------------------------------------------------------
   // Scan counters
   // ---------------------------------------------------------------------------
   logic [CNT_W-1:0] slot_cnt;
   logic [CNT_W-1:0] slot_nxt;
   logic [IDX_W-1:0] dig_idx;
   logic [IDX_W-1:0] dig_nxt;
   logic             slot_end;
   logic             last_dig;
   logic             frame_end;
   logic             frame_done_q;

   assign slot_end  = (slot_cnt == SLOT_LAST);
   assign last_dig  = (dig_idx == DIG_LAST);
   assign frame_end = slot_end & last_dig;

   always_comb begin
      slot_nxt = slot_cnt + 1'b1;
      dig_nxt  = dig_idx;
      if (slot_end) begin
         slot_nxt = '0;
         dig_nxt  = last_dig ? '0 : dig_idx + 1'b1;
      end
   end

   // frame_done is registered but computed from the next counter state, so it
   // is high exactly during the cycle in which slot_cnt/dig_idx are at the
   // frame terminal count (the same cycle the buffer commit happens).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_cnt     <= '0;
         dig_idx      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         slot_cnt     <= slot_nxt;
         dig_idx      <= dig_nxt;
         frame_done_q <= (slot_nxt == SLOT_LAST) && (dig_nxt == DIG_LAST);
      end
   end

   // ---------------------------------------------------------------------------
   // Double buffer
   // ---------------------------------------------------------------------------
   logic [DW-1:0]         pend_digits;
   logic [NUM_DIGITS-1:0] pend_dp;
   logic [NUM_DIGITS-1:0] pend_blank;
   logic                  pend_valid;
   logic [DW-1:0]         disp_digits;
   logic [NUM_DIGITS-1:0] disp_dp;
   logic [NUM_DIGITS-1:0] disp_blank;

   // A load coinciding with the frame end goes straight to the display and
   // supersedes whatever was pending; the pending buffer is drained either way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_digits <= '0;
         pend_dp     <= '0;
         pend_blank  <= '0;
         pend_valid  <= 1'b0;
         disp_digits <= '0;
         disp_dp     <= '0;
         disp_blank  <= '1;
      end else if (frame_end) begin
         if (bus.load) begin
            disp_digits <= bus.digits_in;
            disp_dp     <= bus.dp_in;
            disp_blank  <= bus.blank_in;
         end else if (pend_valid) begin
            disp_digits <= pend_digits;
            disp_dp     <= pend_dp;
            disp_blank  <= pend_blank;
         end
         pend_valid <= 1'b0;
      end else if (bus.load) begin
         pend_digits <= bus.digits_in;
         pend_dp     <= bus.dp_in;
         pend_blank  <= bus.blank_in;
         pend_valid  <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------------
   function automatic logic [6:0] glyph(input logic [3:0] code);
      logic [6:0] g;
      g = '1;
      case (code)
         4'h0: g = 7'b0000001;
         4'h1: g = 7'b1001111;
         4'h2: g = 7'b0010010;
         4'h3: g = 7'b0000110;
         4'h4: g = 7'b1001100;
         4'h5: g = 7'b0100100;
         4'h6: g = 7'b0100000;
         4'h7: g = 7'b0001111;
         4'h8: g = 7'b0000000;
         4'h9: g = 7'b0000100;
         4'hA: g = (HEX_EN != 0) ? 7'b0001000 : 7'b1111110;
         4'hB: g = (HEX_EN != 0) ? 7'b1100000 : 7'b1111110;
         4'hC: g = (HEX_EN != 0) ? 7'b0110001 : 7'b1111110;
         4'hD: g = (HEX_EN != 0) ? 7'b1000010 : 7'b1111110;
         4'hE: g = (HEX_EN != 0) ? 7'b0110000 : 7'b1111110;
         4'hF: g = (HEX_EN != 0) ? 7'b0111000 : 7'b1111111;
      endcase
      return g;
   endfunction

   // zero_run[i] = digit i and every more-significant digit hold code 0.
   // Built from the top down with a running flag.
   logic [NUM_DIGITS-1:0] zero_run;
   logic                  run;

   always_comb begin
      zero_run = '0;
      run      = 1'b1;
      for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
         run = run & (disp_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
         zero_run[NUM_DIGITS-1-k] = run;
      end
   end

   logic [3:0] cur_code;
   logic       cur_dark;
   logic       in_gap;

   assign cur_code = disp_digits[{dig_idx, 2'b00} +: 4];
   // Digit 0 is never zero-suppressed so a value of 0 still shows one '0'.
   assign cur_dark = disp_blank[dig_idx]
                   | (bus.lz_en & zero_run[dig_idx] & (dig_idx != '0));

   generate
      if (BLANK_CYC > 0) begin : g_gap
         assign in_gap = (slot_cnt < CNT_W'(BLANK_CYC));
      end else begin : g_no_gap
         assign in_gap = 1'b0;
      end
   endgenerate

   // ---------------------------------------------------------------------------
   // Registered pin outputs (one cycle behind the counters)
   // ---------------------------------------------------------------------------
   logic [NUM_DIGITS-1:0] anode_nxt;
   logic [6:0]            seg_nxt;
   logic                  dp_nxt;
   logic [NUM_DIGITS-1:0] anode_q;
   logic [6:0]            seg_q;
   logic                  dp_q;

   // Segment and dp lines carry the current digit even during the gap, so
   // they have settled before its anode switches on.
   always_comb begin
      anode_nxt = '1;
      if (!in_gap) begin
         anode_nxt[dig_idx] = 1'b0;
      end
      seg_nxt = cur_dark ? 7'b1111111 : glyph(cur_code);
      // A zero-suppressed digit keeps its dp; only a forced blank hides it.
      dp_nxt  = disp_blank[dig_idx] ? 1'b1 : ~disp_dp[dig_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         anode_q <= '1;
         seg_q   <= '1;
         dp_q    <= 1'b1;
      end else begin
         anode_q <= anode_nxt;
         seg_q   <= seg_nxt;
         dp_q    <= dp_nxt;
      end
   end

   assign bus.anode      = anode_q;
   assign bus.segment    = seg_q;
   assign bus.dp         = dp_q;
   assign bus.frame_done = frame_done_q;

endmodule
